cve2_instr_mem_responder: RTL and testbench
===========================================

CVE2_INSTR_MEM_RESPONDER -- requirements
Module: cve2_instr_mem_responder

Interface
REQ-001 Parameter NUM_OUTSTANDING, default 2, gives the maximum granted-but-unanswered fetches (>=1).
REQ-002 Parameter RESP_LATENCY, default 2, gives the cycles from grant to rvalid (>=1).
REQ-003 Parameter MEM_BASE, default 32'h0000_1000, is the byte base address of the backing memory.
REQ-004 Parameter MEM_WORDS, default 1024, is the backing memory depth in 32-bit words (power of two).
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 instr_req_i  in  1  fetch request from core.
REQ-008 instr_addr_i  in  32  fetch byte address; bits [1:0] ignored.
REQ-009 instr_gnt_o  out  1  request accepted this cycle.
REQ-010 instr_rvalid_o  out  1  response valid; the core always accepts it (no ready).
REQ-011 instr_rdata_o  out  32  response word.
REQ-012 instr_err_o  out  1  response bus error, qualified by rvalid.
REQ-013 stall_i  in  1  grant throttle for backpressure testing.
REQ-014 mem_req_o  out  1  backing SRAM read strobe.
REQ-015 mem_addr_o  out  $clog2(MEM_WORDS)  SRAM word index.
REQ-016 mem_rdata_i  in  32  SRAM read data, valid exactly one cycle after mem_req_o.

Function
REQ-017 Outstanding counter cnt, width $clog2(NUM_OUTSTANDING+1): +1 on grant, -1 on rvalid, unchanged when both occur in one cycle.
REQ-018 instr_gnt_o = instr_req_i & ~stall_i & ((cnt < NUM_OUTSTANDING) | instr_rvalid_o); combinational, with no path from instr_gnt_o back to instr_req_i.
REQ-019 In range: MEM_BASE <= addr < MEM_BASE + 4*MEM_WORDS, compared in 33-bit arithmetic so the upper bound cannot wrap.
REQ-020 Granted and in range: mem_req_o=1 and mem_addr_o=(addr-MEM_BASE)>>2 in the grant cycle; otherwise mem_req_o=0 and mem_addr_o=0.
REQ-021 Granted and out of range: no SRAM access, and the response carries err=1 and rdata=32'h0.
REQ-022 Each grant enters an in-order delay pipeline of RESP_LATENCY stages holding valid and err; data is captured from mem_rdata_i in the stage one cycle after grant.
REQ-023 instr_rvalid_o is asserted exactly RESP_LATENCY cycles after the grant, for one cycle per grant.
REQ-024 Responses are returned strictly in grant order; back-to-back grants yield back-to-back rvalid.
REQ-025 RESP_LATENCY==1: instr_rdata_o is driven from mem_rdata_i directly (masked to 0 on err); otherwise from the last pipeline stage.
REQ-026 instr_rdata_o=0 whenever instr_rvalid_o=0 or instr_err_o=1; instr_err_o=0 whenever instr_rvalid_o=0.
REQ-027 stall_i blocks new grants only; responses already in flight still complete on schedule.
REQ-028 cnt never exceeds NUM_OUTSTANDING and never underflows; rvalid with cnt==0 is impossible by construction.

Reset
REQ-029 While rst_i=1: cnt=0, all pipeline valid bits 0, instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, mem_req_o=0, mem_addr_o=0.
REQ-030 Reset asserted mid-operation discards all in-flight responses; no rvalid appears for any pre-reset grant.
REQ-031 The first grant is possible in the first cycle with rst_i=0.

Verification
REQ-032 Single fetch (defaults): req addr 32'h0000_1008 -> gnt same cycle, mem_addr_o=2, SRAM returns 32'hDEAD_BEEF -> rvalid 2 cycles after grant, rdata=32'hDEAD_BEEF, err=0.
REQ-033 Out of range: addr 32'h0000_2000 (first byte past end) -> gnt, mem_req_o=0, rvalid 2 cycles later with err=1, rdata=0; addr 32'h0000_0FFC also gives err=1.
REQ-034 Outstanding limit: req held high at 0x1000, 0x1004, 0x1008 with NUM_OUTSTANDING=2 -> two grants, the third granted in the cycle the first rvalid asserts, cnt peaks at 2, responses arrive in order.
REQ-035 Stall: stall_i=1 for 5 cycles with req=1 -> no gnt, prior in-flight response still delivered; gnt in the first cycle after stall_i falls.
REQ-036 Reset mid-flight: two grants issued, then rst_i pulsed for 1 cycle before any rvalid -> no rvalid afterwards, cnt=0, next request granted immediately.
REQ-037 RESP_LATENCY=1, NUM_OUTSTANDING=1, 8 consecutive fetches -> one grant and one rvalid every cycle after the first, data matching SRAM words 0..7.

Source files
------------

// File: rtl/cve2_instr_mem_responder.sv
// Instruction-fetch responder: grants core fetches, reads a backing SRAM and
// returns in-order responses after a fixed latency, flagging out-of-range
// addresses as bus errors.
module cve2_instr_mem_responder #(
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 2,
  parameter logic [31:0] MEM_BASE        = 32'h0000_1000,
  parameter int unsigned MEM_WORDS       = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         stall_i,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(NUM_OUTSTANDING + 1);
  // 33-bit bounds so MEM_BASE + size near 4 GiB cannot wrap to a small value
  localparam logic [32:0] LO = {1'b0, MEM_BASE};
  localparam logic [32:0] HI = LO + 33'(MEM_WORDS) * 33'd4;

  logic [CW-1:0]         r_cnt;
  logic [RESP_LATENCY:1] r_vld_pipe;
  logic [RESP_LATENCY:1] r_err_pipe;
  logic [32:0]           w_addr33;
  logic [32:0]           w_off;
  logic                  w_in_range;
  logic                  w_gnt;
  logic                  w_rvalid;
  logic                  w_err;
  logic [31:0]           w_data;
  logic                  w_unused;

  assign w_addr33   = {1'b0, instr_addr_i};
  assign w_in_range = (w_addr33 >= LO) && (w_addr33 < HI);
  assign w_off      = w_addr33 - LO;
  assign w_unused   = ^{w_off[32:AW+2], w_off[1:0]};

  // Reset gates the outputs combinationally so they are quiet in the reset cycle itself
  assign w_rvalid = ~rst_i & r_vld_pipe[RESP_LATENCY];
  assign w_err    = w_rvalid & r_err_pipe[RESP_LATENCY];

  // A response leaving this cycle frees a slot, so a full counter can still grant
  assign w_gnt = ~rst_i & instr_req_i & ~stall_i &
                 ((r_cnt < CW'(NUM_OUTSTANDING)) | w_rvalid);

  assign instr_gnt_o = w_gnt;
  assign mem_req_o   = w_gnt & w_in_range;
  assign mem_addr_o  = mem_req_o ? w_off[AW+1:2] : '0;

  // Outstanding counter: grant and response in the same cycle cancel out
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_gnt, w_rvalid})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Valid/err delay line; stage i is occupied i cycles after the grant
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
      r_err_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_gnt;
      r_err_pipe[1] <= w_gnt & ~w_in_range;
      for (int i = 2; i <= int'(RESP_LATENCY); i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_err_pipe[i] <= r_err_pipe[i-1];
      end
    end
  end

  generate
    if (RESP_LATENCY == 1) begin : g_lat1
      // SRAM data is valid exactly in the response cycle, pass it straight out
      assign w_data = mem_rdata_i;
    end else begin : g_latn
      logic [31:0] r_data_pipe [RESP_LATENCY:2];
      // SRAM data lands one cycle after grant, then rides alongside valid
      always_ff @(posedge clk_i) begin
        r_data_pipe[2] <= mem_rdata_i;
        for (int i = 3; i <= int'(RESP_LATENCY); i++)
          r_data_pipe[i] <= r_data_pipe[i-1];
      end
      assign w_data = r_data_pipe[RESP_LATENCY];
    end
  endgenerate

  assign instr_rvalid_o = w_rvalid;
  assign instr_err_o    = w_err;
  assign instr_rdata_o  = (w_rvalid & ~w_err) ? w_data : 32'h0;

endmodule

// File: tb/tb_cve2_instr_mem_responder.sv
// Self-checking bench: default-parameter responder with a queue scoreboard,
// plus a latency-1 instance and a latency-3 instance that exercises the
// outstanding limit.
module tb_cve2_instr_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  // DUT 0: defaults (latency 2, 2 outstanding)
  logic        req0, stall0, gnt0, rvalid0, err0, mreq0;
  logic [31:0] addr0, rdata0, mrdata0;
  logic [9:0]  maddr0;
  // DUT 1: latency 1, 1 outstanding
  logic        req1, stall1, gnt1, rvalid1, err1, mreq1;
  logic [31:0] addr1, rdata1, mrdata1;
  logic [9:0]  maddr1;
  // DUT 2: latency 3, 2 outstanding (limit actually blocks)
  logic        req2, stall2, gnt2, rvalid2, err2, mreq2;
  logic [31:0] addr2, rdata2, mrdata2;
  logic [9:0]  maddr2;

  cve2_instr_mem_responder u_dut0 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req0), .instr_addr_i(addr0),
    .instr_gnt_o(gnt0), .instr_rvalid_o(rvalid0), .instr_rdata_o(rdata0),
    .instr_err_o(err0), .stall_i(stall0), .mem_req_o(mreq0),
    .mem_addr_o(maddr0), .mem_rdata_i(mrdata0));

  cve2_instr_mem_responder #(.NUM_OUTSTANDING(1), .RESP_LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req1), .instr_addr_i(addr1),
    .instr_gnt_o(gnt1), .instr_rvalid_o(rvalid1), .instr_rdata_o(rdata1),
    .instr_err_o(err1), .stall_i(stall1), .mem_req_o(mreq1),
    .mem_addr_o(maddr1), .mem_rdata_i(mrdata1));

  cve2_instr_mem_responder #(.NUM_OUTSTANDING(2), .RESP_LATENCY(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req2), .instr_addr_i(addr2),
    .instr_gnt_o(gnt2), .instr_rvalid_o(rvalid2), .instr_rdata_o(rdata2),
    .instr_err_o(err2), .stall_i(stall2), .mem_req_o(mreq2),
    .mem_addr_o(maddr2), .mem_rdata_i(mrdata2));

  function automatic logic [31:0] sram_word(input logic [9:0] i);
    return (i == 10'd2) ? 32'hDEAD_BEEF : ({16'hC0DE, 6'd0, i} ^ 32'h0000_5A00);
  endfunction

  // Expected response for a fetch granted in cycle c (default map: 0x1000..0x1FFF)
  function automatic exp_t exp_for(input logic [31:0] a, input int c);
    exp_t e;
    logic [32:0] a33;
    a33   = {1'b0, a};
    e.cyc = c;
    if (a33 >= 33'h1000 && a33 < 33'h2000) begin
      e.err  = 1'b0;
      e.data = sram_word(a[11:2]);
    end else begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end
    return e;
  endfunction

  // SRAM stubs: data one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    mrdata0 <= mreq0 ? sram_word(maddr0) : 32'hBAD0_BAD0;
    mrdata1 <= mreq1 ? sram_word(maddr1) : 32'hBAD1_BAD1;
    mrdata2 <= mreq2 ? sram_word(maddr2) : 32'hBAD2_BAD2;
  end

  // Scoreboard for DUT 0: push on grant, pop/compare on rvalid
  exp_t q0[$];
  exp_t e0;
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
    end else begin
      if (rvalid0) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL sb0_unexpected_rvalid cyc=%0d rdata=%h err=%b", cyc, rdata0, err0);
        end else begin
          e0 = q0.pop_front();
          if ({rdata0, err0} !== {e0.data, e0.err} || cyc != e0.cyc + 2) begin
            failures++;
            $display("FAIL sb0_resp got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                     rdata0, err0, cyc, e0.data, e0.err, e0.cyc + 2);
          end
        end
      end else begin
        checks++;
        if ({rdata0, err0} !== 33'h0) begin
          failures++;
          $display("FAIL sb0_idle_quiet got rdata=%h err=%b want 0/0", rdata0, err0);
        end
      end
      if (gnt0) q0.push_back(exp_for(addr0, cyc));
    end
  end

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; addr0 = 32'h1000; stall0 = 1'b0;
    req1 = 1'b1; addr1 = 32'h1000; stall1 = 1'b0;
    req2 = 1'b0; addr2 = 32'h1000; stall2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt0, rvalid0, err0, mreq0, rdata0, maddr0} !== '0 || gnt1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b rv=%b err=%b mreq=%b rdata=%h maddr=%0d gnt1=%b want all 0",
               gnt0, rvalid0, err0, mreq0, rdata0, maddr0, gnt1);
    end
    checks++;
    if (u_dut0.r_cnt !== 2'd0 || u_dut0.r_vld_pipe !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got cnt=%0d vld=%b want 0/00", u_dut0.r_cnt, u_dut0.r_vld_pipe);
    end
    @(posedge clk); #1 rst = 1'b0; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || mreq0 !== 1'b1 || maddr0 !== 10'd0) begin
      failures++;
      $display("FAIL first_grant_after_reset got gnt=%b mreq=%b maddr=%0d want 1/1/0", gnt0, mreq0, maddr0);
    end
    @(posedge clk); #1 req0 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single();
    @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h0000_1008;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || mreq0 !== 1'b1 || maddr0 !== 10'd2) begin
      failures++;
      $display("FAIL single_grant got gnt=%b mreq=%b maddr=%0d want 1/1/2", gnt0, mreq0, maddr0);
    end
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0) begin
      failures++;
      $display("FAIL single_early_rvalid got rv=%b want 0", rvalid0);
    end
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF || err0 !== 1'b0) begin
      failures++;
      $display("FAIL single_resp got rv=%b rdata=%h err=%b want 1/deadbeef/0", rvalid0, rdata0, err0);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_range();
    logic [31:0] addrs [4];
    logic        xreq  [4];
    logic [9:0]  xaddr [4];
    addrs = '{32'h0000_2000, 32'h0000_0FFC, 32'hFFFF_FFFC, 32'h0000_1FFC};
    xreq  = '{1'b0, 1'b0, 1'b0, 1'b1};
    xaddr = '{10'd0, 10'd0, 10'd0, 10'd1023};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 req0 = 1'b1; addr0 = addrs[i];
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1 || mreq0 !== xreq[i] || maddr0 !== xaddr[i]) begin
        failures++;
        $display("FAIL range_grant addr=%h got gnt=%b mreq=%b maddr=%0d want 1/%b/%0d",
                 addrs[i], gnt0, mreq0, maddr0, xreq[i], xaddr[i]);
      end
      @(posedge clk); #1 req0 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rvalid0 !== 1'b1 || err0 !== ~xreq[i] ||
          rdata0 !== (xreq[i] ? sram_word(xaddr[i]) : 32'h0)) begin
        failures++;
        $display("FAIL range_resp addr=%h got rv=%b err=%b rdata=%h want err=%b", addrs[i],
                 rvalid0, err0, rdata0, ~xreq[i]);
      end
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_outstanding();
    logic [31:0] addrs [3];
    int gc [3];
    int idx = 0;
    addrs = '{32'h1000, 32'h1004, 32'h1008};
    @(posedge clk); #1 req0 = 1'b1; addr0 = addrs[0];
    for (int k = 0; k < 10 && idx < 3; k++) begin
      @(negedge clk);
      if (gnt0) begin
        gc[idx] = cyc;
        if (idx == 2) begin
          checks++;
          if (rvalid0 !== 1'b1 || u_dut0.r_cnt !== 2'd2) begin
            failures++;
            $display("FAIL outstanding_third got rv=%b cnt=%0d want 1/2", rvalid0, u_dut0.r_cnt);
          end
        end
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 3) addr0 = addrs[idx]; else req0 = 1'b0;
    end
    req0 = 1'b0;
    checks++;
    if (idx != 3) begin
      failures++;
      $display("FAIL outstanding_timeout got grants=%0d want 3", idx);
    end else begin
      checks++;
      if (gc[1] != gc[0] + 1 || gc[2] != gc[0] + 2) begin
        failures++;
        $display("FAIL outstanding_timing got grant cycles +%0d,+%0d want +1,+2",
                 gc[1] - gc[0], gc[2] - gc[0]);
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_stall();
    logic saw_rv = 1'b0;
    @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h1004; stall0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL stall_pre_grant got gnt=%b want 1", gnt0);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 stall0 = 1'b1; addr0 = 32'h100C;
      @(negedge clk);
      saw_rv |= rvalid0;
      checks++;
      if (gnt0 !== 1'b0) begin
        failures++;
        $display("FAIL stall_blocks cycle=%0d got gnt=%b want 0", k, gnt0);
      end
    end
    checks++;
    if (saw_rv !== 1'b1) begin
      failures++;
      $display("FAIL stall_inflight got rvalid_seen=%b want 1", saw_rv);
    end
    @(posedge clk); #1 stall0 = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got gnt=%b want 1", gnt0);
    end
    @(posedge clk); #1 req0 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h1000;
    @(posedge clk); #1 addr0 = 32'h1004;
    @(posedge clk); #1 req0 = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0 || gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet got rv=%b gnt=%b want 0/0", rvalid0, gnt0);
    end
    @(posedge clk); #1 rst = 1'b0; req0 = 1'b1; addr0 = 32'h1010;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || rvalid0 !== 1'b0 || u_dut0.r_cnt !== 2'd0) begin
      failures++;
      $display("FAIL midreset_after got gnt=%b rv=%b cnt=%0d want 1/0/0", gnt0, rvalid0, u_dut0.r_cnt);
    end
    @(posedge clk); #1 req0 = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_lat1();
    logic [31:0] q1[$];
    logic [31:0] e;
    int ng = 0;
    @(posedge clk); #1 req1 = 1'b1; addr1 = 32'h1000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (gnt1 !== (k < 8) || rvalid1 !== (k >= 1 && k <= 8)) begin
        failures++;
        $display("FAIL lat1_handshake k=%0d got gnt=%b rv=%b want %b/%b", k, gnt1, rvalid1,
                 (k < 8), (k >= 1 && k <= 8));
      end
      if (rvalid1) begin
        checks++;
        e = (q1.size() != 0) ? q1.pop_front() : 32'hFFFF_FFFF;
        if (rdata1 !== e || err1 !== 1'b0) begin
          failures++;
          $display("FAIL lat1_data k=%0d got rdata=%h err=%b want %h/0", k, rdata1, err1, e);
        end
      end
      if (gnt1) begin
        q1.push_back(sram_word(addr1[11:2]));
        ng++;
      end
      @(posedge clk); #1;
      if (ng < 8) addr1 = 32'h1000 + 32'(ng) * 4; else req1 = 1'b0;
    end
    req1 = 1'b0;
  endtask

  task automatic test_limit();
    logic [31:0] q2[$];
    logic [31:0] e;
    int ng = 0;
    logic xg, xr;
    @(posedge clk); #1 req2 = 1'b1; addr2 = 32'h1010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      xg = (k == 0 || k == 1 || k == 3 || k == 4);
      xr = (k == 3 || k == 4 || k == 6 || k == 7);
      checks++;
      if (gnt2 !== xg || rvalid2 !== xr) begin
        failures++;
        $display("FAIL limit_handshake k=%0d got gnt=%b rv=%b want %b/%b", k, gnt2, rvalid2, xg, xr);
      end
      if (k == 2) begin
        checks++;
        if (u_dut2.r_cnt !== 2'd2) begin
          failures++;
          $display("FAIL limit_cnt got cnt=%0d want 2", u_dut2.r_cnt);
        end
      end
      if (rvalid2) begin
        checks++;
        e = (q2.size() != 0) ? q2.pop_front() : 32'hFFFF_FFFF;
        if (rdata2 !== e || err2 !== 1'b0) begin
          failures++;
          $display("FAIL limit_data k=%0d got rdata=%h err=%b want %h/0", k, rdata2, err2, e);
        end
      end
      if (gnt2) begin
        q2.push_back(sram_word(addr2[11:2]));
        ng++;
      end
      @(posedge clk); #1;
      if (ng < 4) addr2 = 32'h1010 + 32'(ng) * 4; else req2 = 1'b0;
    end
    req2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_range();
    test_outstanding();
    test_stall();
    test_reset_midflight();
    test_lat1();
    test_limit();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL sb0_drain got %0d pending responses want 0", q0.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
